// File: rtl/random_perm_gen_pkg.sv
// Shared constants and helpers for the random permutation generator.
// Optional feature macro: RANDOM_PERM_GEN_SEED_LOAD_EN (runtime seed load port).
package random_perm_gen_pkg;

    // Reset seed used whenever a requested seed is zero.
    localparam logic [31:0] DEFAULT_SEED = 32'h92D6_8CA2;

    // xorshift32 shift amounts, applied in this order: left, right, left.
    localparam int SHIFT_A = 13;
    localparam int SHIFT_B = 17;
    localparam int SHIFT_C = 5;

    // Permutation geometry: 16 elements, each one nibble wide.
    localparam int NIB_W  = 4;
    localparam int N_ELEM = 16;
    localparam int POOL_W = 64;

    // One xorshift32 step. Never maps a nonzero value to zero.
    function automatic logic [31:0] xs_step(input logic [31:0] x);
        logic [31:0] t;
        t = x ^ (x << SHIFT_A);
        t = t ^ (t >> SHIFT_B);
        t = t ^ (t << SHIFT_C);
        return t;
    endfunction

    // A zero state would lock the generator at zero, so zero maps to the default.
    function automatic logic [31:0] fix_seed(input logic [31:0] s);
        return (s == 32'h0) ? DEFAULT_SEED : s;
    endfunction

    // Remainder of a nibble by a small modulus (1..16).
    function automatic logic [3:0] nib_mod(input logic [3:0] v, input logic [4:0] m);
        logic [4:0] r;
        r = {1'b0, v} % m;
        return r[3:0];
    endfunction

endpackage

// File: rtl/random_perm_gen_xorshift32.sv
// xorshift32 state register: advances one step per enabled clock edge.
// Optional feature macro: RANDOM_PERM_GEN_SEED_LOAD_EN adds seed_load/seed,
// which reload the state and take priority over en.
module xorshift32
    import random_perm_gen_pkg::*;
#(
    parameter logic [31:0] SEED = DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
`ifdef RANDOM_PERM_GEN_SEED_LOAD_EN
    input  logic        seed_load,
    input  logic [31:0] seed,
`endif
    output logic [31:0] res
);

    localparam logic [31:0] RESET_STATE = fix_seed(SEED);

    logic [31:0] state;

    // State register: async reset to the seed, optional reload, else step on en.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RESET_STATE;
`ifdef RANDOM_PERM_GEN_SEED_LOAD_EN
        end else if (seed_load) begin
            state <= fix_seed(seed);
`endif
        end else if (en) begin
            state <= xs_step(state);
        end
    end

    assign res = state;

endmodule

// File: rtl/random_perm_gen.sv
// Random permutation generator: an xorshift32 state plus its previous value
// form a 64-bit pool that a combinational Fisher-Yates network turns into a
// permutation of 0..15 (one nibble per position).
// Optional feature macro: RANDOM_PERM_GEN_SEED_LOAD_EN adds seed_load/seed.
module random_perm_gen
    import random_perm_gen_pkg::*;
#(
    parameter logic [31:0] SEED = DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
`ifdef RANDOM_PERM_GEN_SEED_LOAD_EN
    input  logic        seed_load,
    input  logic [31:0] seed,
`endif
    output logic [31:0] rotaryPos,
    output logic [63:0] seq_all
);

    logic [31:0]              state;
    logic [31:0]              prev;
    logic [POOL_W-1:0]        pool;
    logic [N_ELEM-1:0][3:0]   arr;
    logic [3:0]               j_idx;
    logic [3:0]               tmp;

    xorshift32 #(
        .SEED      (SEED)
    ) u_xs (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
`ifdef RANDOM_PERM_GEN_SEED_LOAD_EN
        .seed_load (seed_load),
        .seed      (seed),
`endif
        .res       (state)
    );

    // Previous-state register: captures the old state whenever the state steps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev <= 32'h0;
`ifdef RANDOM_PERM_GEN_SEED_LOAD_EN
        end else if (seed_load) begin
            prev <= 32'h0;
`endif
        end else if (en) begin
            prev <= state;
        end
    end

    assign pool      = {state, prev};
    assign rotaryPos = state;

    // Fisher-Yates shuffle of the identity; pool nibble 0 is never consulted.
    always_comb begin
        arr   = '0;
        j_idx = '0;
        tmp   = '0;
        for (int p = 0; p < N_ELEM; p++) begin
            arr[p] = 4'(p);
        end
        for (int i = N_ELEM - 1; i >= 1; i--) begin
            j_idx      = nib_mod(pool[i*NIB_W +: NIB_W], 5'(i + 1));
            tmp        = arr[j_idx];
            arr[j_idx] = arr[i];
            arr[i]     = tmp;
        end
        seq_all = arr;
    end

endmodule

// File: tb/tb_random_perm_gen.sv
// Self-checking bench for random_perm_gen against a software model.
// Seed-load scenarios run only when RANDOM_PERM_GEN_SEED_LOAD_EN is defined.
module tb_random_perm_gen;

    logic        clk;
    logic        rst;
    logic        en;
    logic [31:0] rotary_pos;
    logic [63:0] seq_all;
`ifdef RANDOM_PERM_GEN_SEED_LOAD_EN
    logic        seed_load;
    logic [31:0] seed;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;

    // model registers
    logic [31:0] m_state;
    logic [31:0] m_prev;

    random_perm_gen dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
`ifdef RANDOM_PERM_GEN_SEED_LOAD_EN
        .seed_load (seed_load),
        .seed      (seed),
`endif
        .rotaryPos (rotary_pos),
        .seq_all   (seq_all)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [31:0] xs_model(input logic [31:0] x);
        logic [31:0] t;
        t = x ^ (x << 13);
        t = t ^ (t >> 17);
        t = t ^ (t << 5);
        return t;
    endfunction

    function automatic logic [63:0] perm_model(input logic [63:0] pool);
        int a[16];
        int j;
        int t;
        logic [63:0] r;
        for (int p = 0; p < 16; p++) a[p] = p;
        for (int i = 15; i >= 1; i--) begin
            j    = int'(pool[4*i +: 4]) % (i + 1);
            t    = a[i];
            a[i] = a[j];
            a[j] = t;
        end
        r = '0;
        for (int p = 0; p < 16; p++) r[4*p +: 4] = 4'(a[p]);
        return r;
    endfunction

    function automatic bit all_distinct(input logic [63:0] v);
        bit seen[16];
        for (int p = 0; p < 16; p++) seen[p] = 1'b0;
        for (int p = 0; p < 16; p++) begin
            if (seen[int'(v[4*p +: 4])]) return 1'b0;
            seen[int'(v[4*p +: 4])] = 1'b1;
        end
        return 1'b1;
    endfunction

    // ---------------- driver helpers ----------------
    task automatic clk_step(input logic en_val);
        en = en_val;
        @(posedge clk);
        #1;
        if (en_val) begin
            m_prev  = m_state;
            m_state = xs_model(m_state);
        end
    endtask

    task automatic check_outputs(input string name);
        logic [63:0] exp_seq;
        exp_seq = perm_model({m_state, m_prev});
        total_cnt++;
        if (rotary_pos !== m_state)
            $display("FAIL %s rotaryPos: got %h expected %h", name, rotary_pos, m_state);
        else pass_cnt++;
        total_cnt++;
        if (seq_all !== exp_seq)
            $display("FAIL %s seq_all: got %h expected %h", name, seq_all, exp_seq);
        else pass_cnt++;
        total_cnt++;
        if (all_distinct(seq_all) !== 1'b1)
            $display("FAIL %s distinct: got %h (repeated nibble) expected a permutation", name, seq_all);
        else pass_cnt++;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        en  = 1'b1;
        #12;
        m_state = 32'h92D6_8CA2;
        m_prev  = 32'h0;
        total_cnt++;
        if (rotary_pos !== 32'd2463534242)
            $display("FAIL reset_seed: got %h expected %h", rotary_pos, 32'h92D6_8CA2);
        else pass_cnt++;
        check_outputs("reset");
        // clock edges during reset must not advance anything
        @(posedge clk);
        @(posedge clk);
        #1;
        check_outputs("reset_hold");
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_first_step();
        clk_step(1'b1);
        total_cnt++;
        if (rotary_pos !== 32'd723471715)
            $display("FAIL first_step: got %0d expected %0d", rotary_pos, 723471715);
        else pass_cnt++;
        total_cnt++;
        if (seq_all !== perm_model({32'd723471715, 32'h92D6_8CA2}))
            $display("FAIL first_step_seq: got %h expected %h", seq_all,
                     perm_model({32'd723471715, 32'h92D6_8CA2}));
        else pass_cnt++;
        check_outputs("first_step_model");
    endtask

    task automatic test_run60();
        for (int k = 0; k < 60; k++) begin
            clk_step(1'b1);
            check_outputs("run60");
        end
    endtask

    task automatic test_hold();
        logic [31:0] r0;
        logic [63:0] s0;
        r0 = rotary_pos;
        s0 = seq_all;
        for (int k = 0; k < 5; k++) clk_step(1'b0);
        total_cnt++;
        if (rotary_pos !== r0)
            $display("FAIL hold_rotary: got %h expected %h", rotary_pos, r0);
        else pass_cnt++;
        total_cnt++;
        if (seq_all !== s0)
            $display("FAIL hold_seq: got %h expected %h", seq_all, s0);
        else pass_cnt++;
        check_outputs("hold_model");
    endtask

    task automatic test_random_en();
        for (int k = 0; k < 80; k++) begin
            clk_step(1'($urandom_range(0, 1)));
            check_outputs("random_en");
        end
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < 7; k++) clk_step(1'b1);
        // assert between edges, check before the next rising edge
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        m_state = 32'h92D6_8CA2;
        m_prev  = 32'h0;
        total_cnt++;
        if (rotary_pos !== 32'h92D6_8CA2)
            $display("FAIL async_reset: got %h expected %h", rotary_pos, 32'h92D6_8CA2);
        else pass_cnt++;
        check_outputs("async_reset");
        @(negedge clk);
        rst = 1'b0;
        clk_step(1'b1);
        check_outputs("after_reset");
    endtask

`ifdef RANDOM_PERM_GEN_SEED_LOAD_EN
    task automatic test_seed_load();
        for (int k = 0; k < 3; k++) clk_step(1'b1);
        seed_load = 1'b1;
        seed      = 32'h0;
        en        = 1'b1;
        @(posedge clk);
        #1;
        m_state = 32'h92D6_8CA2;
        m_prev  = 32'h0;
        total_cnt++;
        if (rotary_pos !== 32'h92D6_8CA2)
            $display("FAIL seed_zero: got %h expected %h", rotary_pos, 32'h92D6_8CA2);
        else pass_cnt++;
        check_outputs("seed_zero");
        seed = 32'h1;
        @(posedge clk);
        #1;
        m_state = 32'h1;
        m_prev  = 32'h0;
        total_cnt++;
        if (rotary_pos !== 32'h1)
            $display("FAIL seed_one: got %h expected %h", rotary_pos, 32'h1);
        else pass_cnt++;
        check_outputs("seed_one");
        seed_load = 1'b0;
        clk_step(1'b1);
        total_cnt++;
        if (rotary_pos !== 32'h0004_2021)
            $display("FAIL seed_one_step: got %h expected %h", rotary_pos, 32'h0004_2021);
        else pass_cnt++;
        check_outputs("seed_one_step");
        // random seeds, including the priority of seed_load over en
        for (int k = 0; k < 10; k++) begin
            seed_load = 1'b1;
            seed      = $urandom;
            @(posedge clk);
            #1;
            m_state = (seed == 32'h0) ? 32'h92D6_8CA2 : seed;
            m_prev  = 32'h0;
            check_outputs("seed_rand");
            seed_load = 1'b0;
            clk_step(1'b1);
            check_outputs("seed_rand_step");
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        en  = 1'b0;
`ifdef RANDOM_PERM_GEN_SEED_LOAD_EN
        seed_load = 1'b0;
        seed      = 32'h0;
`endif
        test_reset();
        test_first_step();
        test_run60();
        test_hold();
        test_random_en();
        test_async_reset();
`ifdef RANDOM_PERM_GEN_SEED_LOAD_EN
        test_seed_load();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/random_perm_gen.md
RANDOM_PERM_GEN -- requirements
Module: random_perm_gen

Interface
REQ-001 SHALL have parameter SEED, default 32'h92D6_8CA2, xorshift reset seed; a value of 0 is replaced by the default.
REQ-002 SHALL have port clk  input  1  single clock, rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port en  input  1  advance the generator on this clock edge.
REQ-005 SHALL have port rotaryPos  output  32  current xorshift32 state.
REQ-006 SHALL have port seq_all  output  64  16 nibbles forming a permutation of 0..15; nibble p is seq_all[4p+3:4p].

Function
REQ-007 SHALL hold two 32-bit registers: state and prev.
- On a clk rising edge with en=1: prev <= state; state <= xs(state).
- With en=0 both registers hold.
REQ-008 SHALL compute xs(x) as three steps, all arithmetic mod 2^32:
- t = x ^ (x << 13)
- t = t ^ (t >> 17)
- t = t ^ (t << 5)
REQ-009 SHALL drive rotaryPos = state, combinationally from the register, with no extra latency.
REQ-010 SHALL form a 64-bit pool = {state, prev}.
REQ-011 SHALL derive seq_all combinationally from pool by Fisher-Yates:
- Start array a[p] = p.
- For i = 15 down to 1: j = pool[4i+3:4i] mod (i+1), then swap a[i] and a[j].
- Output nibble p = a[p].
REQ-012 SHALL make seq_all change only after a state update, i.e. zero cycles after the registers change; pool bits [3:0] are unused.
REQ-013 SHALL keep state nonzero at all times; xs never maps a nonzero value to zero.
REQ-014 SHALL make every seq_all value a valid permutation: all 16 nibbles distinct, for any pool value.

Reset
REQ-015 SHALL set, on rst=1 and independent of clk: state = SEED (or 32'h92D6_8CA2 if SEED==0), prev = 32'h0.
REQ-016 SHALL hold the registers at reset values while rst=1, ignoring en and clk.
- Reset asserted mid-operation discards the sequence immediately.
REQ-017 SHALL drive rotaryPos = reset state and seq_all = the permutation of pool {state_reset, 32'h0} during reset.

Configuration
REQ-018 SHALL support macro RANDOM_PERM_GEN_SEED_LOAD_EN.
- When defined, SHALL add inputs seed_load (1) and seed (32).
- A clock edge with seed_load=1: state <= (seed==0 ? default : seed), prev <= 32'h0, with priority over en.
- When undefined, these ports do not exist and behaviour is as REQ-007.

Structure
REQ-019 SHALL place in a shared package:
- default seed constant 32'h92D6_8CA2;
- shift constants 13, 17, 5;
- nibble width 4 and element count 16.
REQ-020 SHALL implement the state register and xs step as sub-module xorshift32 with ports clk, rst, en, res[31:0].
- random_perm_gen instantiates it and contains the prev register and the combinational shuffle network.

Verification
REQ-021 Reset with default SEED -> rotaryPos = 32'h92D6_8CA2 (2463534242).
- seq_all equals the model permutation of pool {92D68CA2, 00000000}.
REQ-022 Release reset, en=1, one clk edge -> rotaryPos = 723471715 (xs of the seed), prev = 32'h92D6_8CA2.
REQ-023 60 consecutive edges with en=1 -> every cycle seq_all has 16 distinct nibbles and matches the software model bit-exactly.
REQ-024 Hold en=0 for 5 edges -> rotaryPos and seq_all unchanged.
REQ-025 Assert rst asynchronously between edges mid-run -> rotaryPos returns to 32'h92D6_8CA2 before the next clk edge.
REQ-026 With RANDOM_PERM_GEN_SEED_LOAD_EN, seed_load=1 and seed=0 -> rotaryPos = 32'h92D6_8CA2.
- With seed=32'h1 -> rotaryPos = 1, and the next edge gives 32'h0004_2021.
